// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - decode issue/bubble/flush/freeze sequencer with SRAM wait FSM
// Also keeps a saturating stall-cycle counter and a sticky SRAM timeout flag.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_first_src,
    input  logic [3:0]       i_second_src,
    input  logic             i_two_src,
    input  logic [3:0]       i_exe_dest,
    input  logic             i_exe_wb_en,
    input  logic             i_exe_mem_r_en,
    input  logic [3:0]       i_mem_dest,
    input  logic             i_mem_wb_en,
    input  logic             i_forward_en,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_sram_ready,
    input  logic             i_stat_clr,
    output logic             o_id_freeze,
    output logic             o_if_hold,
    output logic             o_flush,
    output logic             o_pipe_freeze,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_count
);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WW-1:0]    r_wait_cnt;
    logic [WW-1:0]    w_wait_cnt_nxt;
    logic             r_mem_timeout;
    logic             w_mem_timeout_nxt;
    logic [CNT_W-1:0] r_stall_count;

    logic w_exe_match;
    logic w_mem_match;
    logic w_hz;
    logic w_last;
    logic w_mwait;
    logic w_hold;

    assign w_exe_match = (i_first_src == i_exe_dest) | (i_two_src & (i_second_src == i_exe_dest));
    assign w_mem_match = (i_first_src == i_mem_dest) | (i_two_src & (i_second_src == i_mem_dest));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign w_hz = i_forward_en ? (i_exe_wb_en & i_exe_mem_r_en & w_exe_match)
                               : ((i_exe_wb_en & w_exe_match) | (i_mem_wb_en & w_mem_match));

    assign w_last  = (r_wait_cnt == WW'(TIMEOUT - 1));
    assign w_mwait = ((r_state == RUN) & i_mem_req & ~i_sram_ready & ~r_mem_timeout)
                   | ((r_state == MEM_WAIT) & ~i_sram_ready & ~w_last);
    assign w_hold  = ~w_mwait & ~i_branch_taken & w_hz;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_timeout <= w_mem_timeout_nxt;
            if (i_stat_clr)
                r_stall_count <= '0;
            else if ((w_mwait | w_hold) && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_mem_timeout_nxt = r_mem_timeout;
        case (r_state)
            RUN: begin
                if (i_mem_req & ~i_sram_ready & ~r_mem_timeout) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = WW'(1);
                end
            end
            MEM_WAIT: begin
                if (i_sram_ready) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (w_last) begin
                    // Access abandoned; later waits are bypassed until reset.
                    w_state_nxt       = RUN;
                    w_wait_cnt_nxt    = '0;
                    w_mem_timeout_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WW'(1);
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_pipe_freeze = ~i_rst & w_mwait;
        o_flush       = ~i_rst & ~w_mwait & i_branch_taken;
        o_if_hold     = ~i_rst & w_hold;
        o_id_freeze   = ~i_rst & w_hold;
        o_mem_timeout = r_mem_timeout;
        o_stall_count = r_stall_count;
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [3:0] fsrc;
        logic [3:0] ssrc;
        logic       two;
        logic [3:0] edst;
        logic       ewb;
        logic       eld;
        logic [3:0] mdst;
        logic       mwb;
        logic       fwd;
        logic       br;
        logic       req;
        logic       rdy;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic       idf;
        logic       hold;
        logic       flush;
        logic       pfz;
        logic       to;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] first_src = '0, second_src = '0, exe_dest = '0, mem_dest = '0;
    logic two_src = 0, exe_wb_en = 0, exe_mem_r_en = 0, mem_wb_en = 0, forward_en = 0;
    logic branch_taken = 0, mem_req = 0, sram_ready = 0, stat_clr = 0;
    logic id_freeze, if_hold, flush, pipe_freeze, mem_timeout;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_first_src(first_src), .i_second_src(second_src), .i_two_src(two_src),
        .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en), .i_exe_mem_r_en(exe_mem_r_en),
        .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb_en), .i_forward_en(forward_en),
        .i_branch_taken(branch_taken), .i_mem_req(mem_req), .i_sram_ready(sram_ready),
        .i_stat_clr(stat_clr),
        .o_id_freeze(id_freeze), .o_if_hold(if_hold), .o_flush(flush),
        .o_pipe_freeze(pipe_freeze), .o_mem_timeout(mem_timeout), .o_stall_count(stall_count)
    );

    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    // Reference model state: timeout flag, freeze cycles spent on the current access, stall total.
    bit m_to = 0;
    int m_frozen = 0;
    int m_cnt = 0;

    function automatic bit reads(stim_t s, logic [3:0] r);
        return (s.fsrc == r) || (s.two && (s.ssrc == r));
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit hz, fz;
        @(posedge clk);
        #1;
        rst = s.rst; first_src = s.fsrc; second_src = s.ssrc; two_src = s.two;
        exe_dest = s.edst; exe_wb_en = s.ewb; exe_mem_r_en = s.eld; mem_dest = s.mdst;
        mem_wb_en = s.mwb; forward_en = s.fwd; branch_taken = s.br; mem_req = s.req;
        sram_ready = s.rdy; stat_clr = s.clr;
        e = '0;
        if (s.rst) begin
            m_to = 0; m_frozen = 0; m_cnt = 0;
        end else begin
            if (s.fwd) hz = s.ewb && s.eld && reads(s, s.edst);
            else       hz = (s.ewb && reads(s, s.edst)) || (s.mwb && reads(s, s.mdst));
            if (m_frozen > 0) fz = !s.rdy && (m_frozen < TIMEOUT - 1);
            else              fz = s.req && !s.rdy && !m_to;
            e.pfz   = fz;
            e.flush = !fz && s.br;
            e.hold  = !fz && !s.br && hz;
            e.idf   = e.hold;
            e.to    = m_to;
            e.cnt   = 8'(m_cnt);
            if (s.clr) m_cnt = 0;
            else if ((fz || e.hold) && m_cnt < CNT_MAX) m_cnt++;
            if (fz) m_frozen++;
            else begin
                if (m_frozen > 0 && !s.rdy) m_to = 1;
                m_frozen = 0;
            end
        end
        sb.push_back(e);
    endtask

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("id_freeze",   int'(id_freeze),   int'(mon_e.idf));
            chk("if_hold",     int'(if_hold),     int'(mon_e.hold));
            chk("flush",       int'(flush),       int'(mon_e.flush));
            chk("pipe_freeze", int'(pipe_freeze), int'(mon_e.pfz));
            chk("mem_timeout", int'(mem_timeout), int'(mon_e.to));
            chk("stall_count", int'(stall_count), int'(mon_e.cnt));
        end
    end

    stim_t s;
    initial begin
        s = '0; s.rst = 1;
        repeat (2) apply(s);
        // Load-use with forwarding, then a non-load producer.
        s = '0; s.fwd = 1; s.edst = 3; s.ewb = 1; s.eld = 1; s.fsrc = 3;
        apply(s);
        s.eld = 0; apply(s);
        // No forwarding: second source against MEM destination.
        s = '0; s.mdst = 5; s.mwb = 1; s.two = 1; s.ssrc = 5; s.fsrc = 1;
        apply(s);
        s.two = 0; apply(s);
        // Branch beats hazard; SRAM wait beats branch.
        s = '0; s.fwd = 1; s.edst = 2; s.ewb = 1; s.eld = 1; s.fsrc = 2; s.br = 1;
        apply(s);
        s.req = 1; apply(s);
        s.br = 0; s.eld = 0; repeat (2) apply(s);
        s.rdy = 1; apply(s);
        s = '0; apply(s);
        // Zero-wait access.
        s.req = 1; s.rdy = 1; apply(s);
        // Unanswered access runs into the timeout, then later requests are bypassed.
        s = '0; s.req = 1; repeat (6) apply(s);
        s = '0; s.req = 1; s.fsrc = 9; s.edst = 9; s.ewb = 1; repeat (3) apply(s);
        // Reset in the middle of a wait.
        s = '0; s.rst = 1; apply(s);
        s = '0; s.req = 1; repeat (2) apply(s);
        s.rst = 1; apply(s);
        s = '0; repeat (2) apply(s);
        // Counter saturation.
        s = '0; s.edst = 4; s.ewb = 1; s.fsrc = 4;
        repeat (10) apply(s);
        s.clr = 1; apply(s);
        s.clr = 0; repeat (2) apply(s);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 59) == 0);
            s.fsrc = 4'($urandom_range(0, 3));
            s.ssrc = 4'($urandom_range(0, 3));
            s.edst = 4'($urandom_range(0, 3));
            s.mdst = 4'($urandom_range(0, 3));
            s.two  = 1'($urandom_range(0, 1));
            s.ewb  = 1'($urandom_range(0, 1));
            s.eld  = 1'($urandom_range(0, 1));
            s.mwb  = 1'($urandom_range(0, 1));
            s.fwd  = 1'($urandom_range(0, 1));
            s.br   = ($urandom_range(0, 7) == 0);
            s.req  = ($urandom_range(0, 2) == 0);
            s.rdy  = ($urandom_range(0, 3) == 0);
            s.clr  = ($urandom_range(0, 15) == 0);
            apply(s);
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
